// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch engine with single outstanding read and decode queue
//
// Issues one memory read per instruction address and buffers returned words
// (with their fetch address) in a small FIFO toward decode.
//
// Ports:
//   clock            - single clock, all state on rising edge
//   i_reset          - synchronous active-high reset
//   i_pc             - address to fetch next
//   o_pc_advance     - one-cycle pulse when i_pc has been accepted by memory
//   i_flush          - redirect: drop queued and in-flight instructions
//   o_mem_req_valid  - read request presented
//   o_mem_addr       - read request address
//   i_mem_req_ready  - memory accepts request this cycle
//   i_mem_rsp_valid  - read data returned this cycle
//   i_mem_rsp_data   - returned instruction word
//   o_inst_valid     - queue head valid
//   o_inst           - queue head instruction word
//   o_inst_address   - queue head fetch address
//   i_decode_ready   - decode consumes the head this cycle
module fetch_unit #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        i_reset,
  input  logic [31:0] i_pc,
  output logic        o_pc_advance,
  input  logic        i_flush,
  output logic        o_mem_req_valid,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_req_ready,
  input  logic        i_mem_rsp_valid,
  input  logic [31:0] i_mem_rsp_data,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_address,
  input  logic        i_decode_ready
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        data_q [QUEUE_DEPTH];
  logic [31:0]        data_d [QUEUE_DEPTH];
  logic [31:0]        addr_q [QUEUE_DEPTH];
  logic [31:0]        addr_d [QUEUE_DEPTH];

  logic push;
  logic pop;
  logic pc_advance;
  logic inst_valid;

  // Fetch FSM. A new request is only launched while the queue has a free
  // slot; since at most one read is outstanding, that slot is still free
  // when the response returns, so the queue never overflows.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    push       = 1'b0;
    pc_advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_flush && (count_q < CNT_W'(QUEUE_DEPTH))) begin
          state_d    = S_REQ;
          mem_addr_d = i_pc;
        end
      end
      S_REQ: begin
        if (i_mem_req_ready) begin
          // Memory took the request even on a flush; its response must be eaten.
          state_d    = i_flush ? S_DROP : S_WAIT;
          pc_advance = !i_flush;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_mem_rsp_valid) begin
          state_d = S_IDLE;
          push    = !i_flush;
        end else if (i_flush) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (i_mem_rsp_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode queue: flush wins over any same-cycle push or pop.
  always_comb begin
    inst_valid = (count_q != '0);
    pop        = inst_valid && i_decode_ready;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    addr_d     = addr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = i_mem_rsp_data;
        addr_d[wr_ptr_q] = mem_addr_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through the valid-gated outputs.
  always_ff @(posedge clock) begin
    data_q <= data_d;
    addr_q <= addr_d;
  end

  assign o_mem_req_valid = (state_q == S_REQ);
  assign o_mem_addr      = mem_addr_q;
  assign o_pc_advance    = pc_advance;
  assign o_inst_valid    = inst_valid;
  assign o_inst          = inst_valid ? data_q[rd_ptr_q] : 32'h0;
  assign o_inst_address  = inst_valid ? addr_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        i_reset = 1'b1;
  logic [31:0] i_pc = '0;
  logic        o_pc_advance;
  logic        i_flush = 1'b0;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_req_ready = 1'b0;
  logic        i_mem_rsp_valid = 1'b0;
  logic [31:0] i_mem_rsp_data = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_address;
  logic        i_decode_ready = 1'b0;

  fetch_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_pc           (i_pc),
    .o_pc_advance   (o_pc_advance),
    .i_flush        (i_flush),
    .o_mem_req_valid(o_mem_req_valid),
    .o_mem_addr     (o_mem_addr),
    .i_mem_req_ready(i_mem_req_ready),
    .i_mem_rsp_valid(i_mem_rsp_valid),
    .i_mem_rsp_data (i_mem_rsp_data),
    .o_inst_valid   (o_inst_valid),
    .o_inst         (o_inst),
    .o_inst_address (o_inst_address),
    .i_decode_ready (i_decode_ready)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level reference: a list of queued (addr, data) pairs plus
  // whether a request is being offered and whether a read is in flight.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  bit          m_req = 0;
  bit          m_infl = 0;
  bit          m_live = 0;
  logic [31:0] m_addr = '0;

  always @(posedge clock) begin
    int sz;
    bit do_pop;
    bit do_push;
    sz = mq.size();
    if (i_reset) begin
      mq.delete();
      m_req  = 0;
      m_infl = 0;
      m_live = 0;
      m_addr = '0;
    end else begin
      do_pop  = (sz > 0) && i_decode_ready;
      do_push = m_infl && m_live && i_mem_rsp_valid && !i_flush;
      if (i_flush) begin
        mq.delete();
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{m_addr, i_mem_rsp_data});
      end
      if (m_req) begin
        if (i_mem_req_ready) begin
          m_req  = 0;
          m_infl = 1;
          m_live = !i_flush;
        end else if (i_flush) begin
          m_req = 0;
        end
      end else if (m_infl) begin
        if (i_mem_rsp_valid) m_infl = 0;
        else if (i_flush) m_live = 0;
      end else if (!i_flush && sz < DEPTH) begin
        m_req  = 1;
        m_addr = i_pc;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("mem_req_valid", o_mem_req_valid, m_req);
      chk("mem_addr", o_mem_addr, m_addr);
      chk("pc_advance", o_pc_advance, m_req && i_mem_req_ready && !i_flush);
      chk("inst_valid", o_inst_valid, mq.size() > 0);
      chk("inst", o_inst, (mq.size() > 0) ? mq[0].d : 32'h0);
      chk("inst_address", o_inst_address, (mq.size() > 0) ? mq[0].a : 32'h0);
    end
  end

  // Bench-side memory and PC register.
  logic [31:0] pc = '0;
  int          rsp_delay = 1;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr = '0;
  int          adv_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic set_pc(input logic [31:0] v);
    pc   = v;
    i_pc = v;
  endtask

  task automatic tick();
    logic        hs;
    logic        adv;
    logic [31:0] ha;
    #1;
    hs  = o_mem_req_valid && i_mem_req_ready;
    ha  = o_mem_addr;
    adv = o_pc_advance;
    @(posedge clock);
    #1;
    if (adv) begin
      pc = pc + 32'd4;
      adv_cnt++;
    end
    i_pc = pc;
    i_mem_rsp_valid = 1'b0;
    if (hs) begin
      rsp_cnt  = rsp_delay;
      rsp_addr = ha;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = mem_word(rsp_addr);
      end
    end
  endtask

  task automatic do_reset();
    i_reset         = 1'b1;
    i_flush         = 1'b0;
    i_mem_req_ready = 1'b0;
    i_decode_ready  = 1'b0;
    rsp_cnt         = 0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Basic single fetch after reset.
    set_pc(32'h100);
    do_reset();
    chk_en = 1;
    set_pc(32'h100);
    chk("rst_req_valid", o_mem_req_valid, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_pc_adv", o_pc_advance, 0);
    chk("rst_inst_valid", o_inst_valid, 0);
    chk("rst_inst", o_inst, 0);
    chk("rst_inst_addr", o_inst_address, 0);
    i_mem_req_ready = 1'b1;
    rsp_delay = 1;
    adv_cnt = 0;
    tick();
    chk("t1_addr", o_mem_addr, 32'h100);
    tick();
    chk("t1_not_yet", o_inst_valid, 0);
    tick();
    chk("t1_valid", o_inst_valid, 1);
    chk("t1_inst", o_inst, 32'hDEADBEEF);
    chk("t1_iaddr", o_inst_address, 32'h100);
    chk("t1_adv_pulses", adv_cnt, 1);

    // Queue fills, stalls, then drains in order.
    do_reset();
    set_pc(32'h0);
    i_mem_req_ready = 1'b1;
    rsp_delay = 1;
    repeat (6) tick();
    chk("t2_head_valid", o_inst_valid, 1);
    chk("t2_head_addr", o_inst_address, 32'h0);
    chk("t2_head_inst", o_inst, 32'hA5A5_0000);
    repeat (6) begin
      tick();
      chk("t2_no_req_full", o_mem_req_valid, 0);
    end
    i_decode_ready = 1'b1;
    tick();
    chk("t2_second_addr", o_inst_address, 32'h4);
    chk("t2_second_inst", o_inst, 32'hA5A5_0004);
    tick();
    chk("t2_resume_req", o_mem_req_valid, 1);
    chk("t2_resume_addr", o_mem_addr, 32'h8);
    chk("t2_drained", o_inst_valid, 0);

    // Back-pressure on the request.
    do_reset();
    set_pc(32'h200);
    i_decode_ready = 1'b1;
    tick();
    repeat (5) begin
      tick();
      chk("t3_req_held", o_mem_req_valid, 1);
      chk("t3_addr_held", o_mem_addr, 32'h200);
      chk("t3_no_adv", o_pc_advance, 0);
    end
    i_mem_req_ready = 1'b1;
    #1;
    chk("t3_adv", o_pc_advance, 1);
    tick();
    chk("t3_accepted", o_mem_req_valid, 0);

    // Flush while waiting; late response must be discarded.
    do_reset();
    set_pc(32'h300);
    i_mem_req_ready = 1'b1;
    i_decode_ready = 1'b1;
    rsp_delay = 4;
    tick();
    tick();
    i_flush = 1'b1;
    set_pc(32'h400);
    tick();
    i_flush = 1'b0;
    n = 0;
    while (!o_mem_req_valid && n < 10) begin
      chk("t4_empty", o_inst_valid, 0);
      tick();
      n++;
    end
    chk("t4_latency", n, 4);
    chk("t4_new_addr", o_mem_addr, 32'h400);
    chk("t4_still_empty", o_inst_valid, 0);

    // Flush on the same cycle as a pop with the queue full.
    do_reset();
    set_pc(32'h500);
    i_mem_req_ready = 1'b1;
    rsp_delay = 1;
    repeat (6) tick();
    chk("t5_full_head", o_inst_address, 32'h500);
    i_decode_ready = 1'b1;
    i_flush = 1'b1;
    set_pc(32'h600);
    tick();
    i_flush = 1'b0;
    chk("t5_flushed", o_inst_valid, 0);
    tick();
    chk("t5_req", o_mem_req_valid, 1);
    chk("t5_req_addr", o_mem_addr, 32'h600);

    // Reset while waiting, stray response follows.
    do_reset();
    set_pc(32'h700);
    i_mem_req_ready = 1'b1;
    i_decode_ready = 1'b1;
    rsp_delay = 2;
    tick();
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t6_req_valid", o_mem_req_valid, 0);
    chk("t6_mem_addr", o_mem_addr, 0);
    chk("t6_pc_adv", o_pc_advance, 0);
    chk("t6_inst_valid", o_inst_valid, 0);
    chk("t6_inst", o_inst, 0);
    chk("t6_inst_addr", o_inst_address, 0);
    repeat (3) begin
      tick();
      chk("t6_no_push", o_inst_valid, 0);
    end
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
